// File: rtl/mand_scheduler.sv
// mand_scheduler: raster-order pixel dispatcher over a pool of mand_solver slots with round-robin result collection.
// Frame statistics counters are built only when MAND_SCHED_STATS_EN is defined.
module mand_scheduler #(
    parameter int NUM_SOLVERS = 4,
    parameter int WIDTH       = 640,
    parameter int HEIGHT      = 480
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       start,
    input  logic [26:0]                x_min,
    input  logic [26:0]                y_max,
    input  logic [26:0]                step,
    output logic [NUM_SOLVERS-1:0]     solver_reset,
    output logic [27*NUM_SOLVERS-1:0]  solver_c_re,
    output logic [27*NUM_SOLVERS-1:0]  solver_c_im,
    input  logic [NUM_SOLVERS-1:0]     solver_ready,
    input  logic [32*NUM_SOLVERS-1:0]  solver_out,
    output logic                       pix_valid,
    input  logic                       pix_ready,
    output logic [9:0]                 pix_x,
    output logic [9:0]                 pix_y,
    output logic [31:0]                pix_iter,
    output logic                       busy,
    output logic                       done,
    output logic [31:0]                frame_cycles,
    output logic [31:0]                conv_count
);
    localparam int PW = NUM_SOLVERS > 1 ? $clog2(NUM_SOLVERS) : 1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_e;
    typedef enum logic [1:0] {SL_FREE, SL_LOAD, SL_BUSY} slot_e;

    state_e      state_q, state_d;
    slot_e       slot_q [NUM_SOLVERS];
    slot_e       slot_d [NUM_SOLVERS];
    logic [26:0] re_q   [NUM_SOLVERS];
    logic [26:0] re_d   [NUM_SOLVERS];
    logic [26:0] im_q   [NUM_SOLVERS];
    logic [26:0] im_d   [NUM_SOLVERS];
    logic [9:0]  sx_q   [NUM_SOLVERS];
    logic [9:0]  sx_d   [NUM_SOLVERS];
    logic [9:0]  sy_q   [NUM_SOLVERS];
    logic [9:0]  sy_d   [NUM_SOLVERS];
    logic [26:0] x_min_q, x_min_d, step_q, step_d;
    logic [26:0] cur_re_q, cur_re_d, cur_im_q, cur_im_d;
    logic [9:0]  x_q, x_d, y_q, y_d;
    logic [PW-1:0] rr_q, rr_d;
    logic        pix_valid_q, pix_valid_d;
    logic [9:0]  pix_x_q, pix_x_d, pix_y_q, pix_y_d;
    logic [31:0] pix_iter_q, pix_iter_d;
    logic        done_q, done_d;
    logic        fire;

    assign fire = pix_valid_q && pix_ready;

    always_comb begin : p_next
        int j;
        int g;
        int d;
        logic all_free;
        j = 0;
        g = -1;
        d = -1;
        all_free = 1'b1;
        state_d = state_q;
        slot_d = slot_q;
        re_d = re_q;
        im_d = im_q;
        sx_d = sx_q;
        sy_d = sy_q;
        x_min_d = x_min_q;
        step_d = step_q;
        cur_re_d = cur_re_q;
        cur_im_d = cur_im_q;
        x_d = x_q;
        y_d = y_q;
        rr_d = rr_q;
        pix_valid_d = pix_valid_q;
        pix_x_d = pix_x_q;
        pix_y_d = pix_y_q;
        pix_iter_d = pix_iter_q;
        done_d = 1'b0;
        for (int k = 0; k < NUM_SOLVERS; k++) begin
            if (slot_q[k] == SL_LOAD) slot_d[k] = SL_BUSY;
            if (slot_q[k] != SL_FREE) all_free = 1'b0;
        end
        // Round-robin search starts at the slot after the last grant
        for (int k = 0; k < NUM_SOLVERS; k++) begin
            j = int'(rr_q) + k;
            if (j >= NUM_SOLVERS) j = j - NUM_SOLVERS;
            if (g < 0 && slot_q[j] == SL_BUSY && solver_ready[j] && (!pix_valid_q || pix_ready)) g = j;
        end
        for (int k = NUM_SOLVERS - 1; k >= 0; k--)
            if (slot_q[k] == SL_FREE) d = k;
        if (g >= 0) begin
            slot_d[g] = SL_FREE;
            rr_d = (g == NUM_SOLVERS - 1) ? '0 : PW'(g + 1);
            pix_valid_d = 1'b1;
            pix_x_d = sx_q[g];
            pix_y_d = sy_q[g];
            pix_iter_d = solver_out[32*g +: 32];
        end else if (fire) begin
            pix_valid_d = 1'b0;
        end
        if (state_q == S_IDLE) begin
            if (start) begin
                state_d = S_RUN;
                x_min_d = x_min;
                step_d = step;
                cur_re_d = x_min;
                cur_im_d = y_max;
                x_d = '0;
                y_d = '0;
            end
        end else if (state_q == S_RUN) begin
            if (d >= 0) begin
                slot_d[d] = SL_LOAD;
                re_d[d] = cur_re_q;
                im_d[d] = cur_im_q;
                sx_d[d] = x_q;
                sy_d[d] = y_q;
                if (x_q == 10'(WIDTH - 1)) begin
                    x_d = '0;
                    y_d = y_q + 10'd1;
                    cur_re_d = x_min_q;
                    cur_im_d = cur_im_q - step_q;
                    if (y_q == 10'(HEIGHT - 1)) state_d = S_DRAIN;
                end else begin
                    x_d = x_q + 10'd1;
                    cur_re_d = cur_re_q + step_q;
                end
            end
        end else begin
            // Last result leaves only when nothing else is in flight or being granted
            if (fire && g < 0 && all_free) begin
                state_d = S_IDLE;
                done_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            for (int k = 0; k < NUM_SOLVERS; k++) begin
                slot_q[k] <= SL_FREE;
                re_q[k] <= '0;
                im_q[k] <= '0;
                sx_q[k] <= '0;
                sy_q[k] <= '0;
            end
            x_min_q <= '0;
            step_q <= '0;
            cur_re_q <= '0;
            cur_im_q <= '0;
            x_q <= '0;
            y_q <= '0;
            rr_q <= '0;
            pix_valid_q <= 1'b0;
            pix_x_q <= '0;
            pix_y_q <= '0;
            pix_iter_q <= '0;
            done_q <= 1'b0;
        end else begin
            state_q <= state_d;
            slot_q <= slot_d;
            re_q <= re_d;
            im_q <= im_d;
            sx_q <= sx_d;
            sy_q <= sy_d;
            x_min_q <= x_min_d;
            step_q <= step_d;
            cur_re_q <= cur_re_d;
            cur_im_q <= cur_im_d;
            x_q <= x_d;
            y_q <= y_d;
            rr_q <= rr_d;
            pix_valid_q <= pix_valid_d;
            pix_x_q <= pix_x_d;
            pix_y_q <= pix_y_d;
            pix_iter_q <= pix_iter_d;
            done_q <= done_d;
        end
    end

    always_comb begin
        solver_reset = '1;
        solver_c_re = '0;
        solver_c_im = '0;
        for (int k = 0; k < NUM_SOLVERS; k++) begin
            solver_reset[k] = slot_q[k] != SL_BUSY;
            solver_c_re[27*k +: 27] = re_q[k];
            solver_c_im[27*k +: 27] = im_q[k];
        end
    end

    assign pix_valid = pix_valid_q;
    assign pix_x = pix_x_q;
    assign pix_y = pix_y_q;
    assign pix_iter = pix_iter_q;
    assign busy = state_q != S_IDLE;
    assign done = done_q;

`ifdef MAND_SCHED_STATS_EN
    logic [31:0] frame_cycles_q, frame_cycles_d, conv_count_q, conv_count_d;

    always_comb begin
        frame_cycles_d = frame_cycles_q;
        conv_count_d = conv_count_q;
        if (state_q == S_IDLE && start) begin
            frame_cycles_d = '0;
            conv_count_d = '0;
        end else begin
            if (state_q != S_IDLE) frame_cycles_d = frame_cycles_q + 32'd1;
            if (fire && pix_iter_q == '1) conv_count_d = conv_count_q + 32'd1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            frame_cycles_q <= '0;
            conv_count_q <= '0;
        end else begin
            frame_cycles_q <= frame_cycles_d;
            conv_count_q <= conv_count_d;
        end
    end

    assign frame_cycles = frame_cycles_q;
    assign conv_count = conv_count_q;
`else
    assign frame_cycles = '0;
    assign conv_count = '0;
`endif
endmodule

// File: tb/tb_mand_scheduler.sv
// tb_mand_scheduler: random-view frames against behavioural solver stand-ins and a raster-order pixel model.
module tb_mand_scheduler;
    localparam int NS = 2;
    localparam int W = 4;
    localparam int H = 2;
    localparam int MAXI = 24;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic start = 1'b0;
    logic [26:0] x_min = '0, y_max = '0, step = '0;
    logic [NS-1:0] solver_reset;
    logic [27*NS-1:0] solver_c_re, solver_c_im;
    logic [NS-1:0] solver_ready = '0;
    logic [32*NS-1:0] solver_out = '0;
    logic pix_valid, pix_ready = 1'b0, busy, done;
    logic [9:0] pix_x, pix_y;
    logic [31:0] pix_iter, frame_cycles, conv_count;

    int n_checks = 0;
    int n_pass = 0;

    logic [26:0] fx_min, fy_max, fstep;
    int rel_k = 0;
    logic [NS-1:0] act = '0;
    int cnt [NS];
    logic [26:0] sr_re, sr_im;

    bit seen [W*H];
    int accepted, nconv, bcyc, cyc, hs_cyc, done_cnt, done_cyc;
    logic done_busy;
    logic hold = 1'b0;
    logic [9:0] hx, hy;
    logic [31:0] hiter;

    always #5 clock = ~clock;

    mand_scheduler #(.NUM_SOLVERS(NS), .WIDTH(W), .HEIGHT(H)) dut (
        .clock(clock), .reset(reset), .start(start),
        .x_min(x_min), .y_max(y_max), .step(step),
        .solver_reset(solver_reset), .solver_c_re(solver_c_re), .solver_c_im(solver_c_im),
        .solver_ready(solver_ready), .solver_out(solver_out),
        .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_x(pix_x), .pix_y(pix_y), .pix_iter(pix_iter),
        .busy(busy), .done(done), .frame_cycles(frame_cycles), .conv_count(conv_count)
    );

    function automatic logic [31:0] mand_iter(input logic [26:0] cr, input logic [26:0] ci);
        longint zr, zi, t, lr, li;
        zr = 0;
        zi = 0;
        lr = longint'($signed(cr));
        li = longint'($signed(ci));
        for (int n = 0; n < MAXI; n++) begin
            if (zr * zr + zi * zi > (longint'(4) <<< 40)) return 32'(n);
            t = ((zr * zr - zi * zi) >>> 20) + lr;
            zi = ((2 * zr * zi) >>> 20) + li;
            zr = t;
        end
        return 32'hFFFF_FFFF;
    endfunction

    function automatic logic [26:0] exp_re(input int k);
        return 27'(longint'($signed(fx_min)) + longint'(k % W) * longint'($signed(fstep)));
    endfunction

    function automatic logic [26:0] exp_im(input int k);
        return 27'(longint'($signed(fy_max)) - longint'(k / W) * longint'($signed(fstep)));
    endfunction

    // Solver stand-ins: capture c on release, answer after a random delay, hold until reset
    always @(negedge clock) begin
        for (int i = 0; i < NS; i++) begin
            if (solver_reset[i] !== 1'b0) begin
                act[i] = 1'b0;
                solver_ready[i] = 1'b0;
            end else if (!act[i]) begin
                sr_re = solver_c_re[27*i +: 27];
                sr_im = solver_c_im[27*i +: 27];
                n_checks++;
                if (sr_re !== exp_re(rel_k) || sr_im !== exp_im(rel_k))
                    $display("FAIL load_c pixel %0d slot %0d: got re=%h im=%h, want re=%h im=%h",
                             rel_k, i, sr_re, sr_im, exp_re(rel_k), exp_im(rel_k));
                else
                    n_pass++;
                solver_out[32*i +: 32] = mand_iter(sr_re, sr_im);
                cnt[i] = int'($urandom_range(0, 10));
                act[i] = 1'b1;
                rel_k++;
            end else if (cnt[i] > 0) begin
                cnt[i]--;
            end else begin
                solver_ready[i] = 1'b1;
            end
        end
    end

    task automatic tick(input logic rdy);
        int k;
        logic [31:0] ei;
        @(negedge clock);
        cyc++;
        if (busy) bcyc++;
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
            done_busy = busy;
        end
        if (hold) begin
            n_checks++;
            if (pix_valid !== 1'b1 || pix_x !== hx || pix_y !== hy || pix_iter !== hiter)
                $display("FAIL hold_stable: got v=%b (%0d,%0d,%h), want v=1 (%0d,%0d,%h)",
                         pix_valid, pix_x, pix_y, pix_iter, hx, hy, hiter);
            else
                n_pass++;
        end
        pix_ready = rdy;
        hold = pix_valid && !rdy;
        hx = pix_x;
        hy = pix_y;
        hiter = pix_iter;
        if (pix_valid && rdy) begin
            n_checks++;
            if (pix_x >= W || pix_y >= H) begin
                $display("FAIL pix_range: got (%0d,%0d), want x<%0d y<%0d", pix_x, pix_y, W, H);
            end else begin
                k = int'(pix_y) * W + int'(pix_x);
                ei = mand_iter(exp_re(k), exp_im(k));
                if (seen[k])
                    $display("FAIL pix_dup: got (%0d,%0d) again, want each pixel once", pix_x, pix_y);
                else if (pix_iter !== ei)
                    $display("FAIL pix_iter (%0d,%0d): got %h, want %h", pix_x, pix_y, pix_iter, ei);
                else
                    n_pass++;
                seen[k] = 1'b1;
                accepted++;
                if (ei == 32'hFFFF_FFFF) nconv++;
                hs_cyc = cyc;
            end
        end
    endtask

    task automatic run_frame(input logic [26:0] xm, input logic [26:0] ym, input logic [26:0] st,
                             input int bp_at, input int bp_len, input bit poke, input int abort_at);
        fx_min = xm;
        fy_max = ym;
        fstep = st;
        rel_k = 0;
        accepted = 0;
        nconv = 0;
        bcyc = 0;
        done_cnt = 0;
        done_cyc = -1;
        done_busy = 1'b1;
        hs_cyc = -100;
        cyc = 0;
        hold = 1'b0;
        for (int k = 0; k < W * H; k++) seen[k] = 1'b0;
        x_min = xm;
        y_max = ym;
        step = st;
        start = 1'b1;
        tick(1'b1);
        start = 1'b0;
        n_checks++;
        if (busy !== 1'b1) $display("FAIL busy_after_start: got %b, want 1", busy);
        else n_pass++;
        tick(1'b1);
        n_checks++;
        if (solver_reset[0] !== 1'b1 || solver_c_re[26:0] !== xm || solver_c_im[26:0] !== ym)
            $display("FAIL slot0_load: got rst=%b re=%h im=%h, want rst=1 re=%h im=%h",
                     solver_reset[0], solver_c_re[26:0], solver_c_im[26:0], xm, ym);
        else
            n_pass++;
        tick(1'b1);
        n_checks++;
        if (solver_reset[0] !== 1'b0) $display("FAIL slot0_release: got %b, want 0", solver_reset[0]);
        else n_pass++;
        for (int t = 0; t < 3000 && done_cnt == 0; t++) begin
            if (poke && t == 4) begin
                n_checks++;
                if (busy !== 1'b1) $display("FAIL busy_at_poke: got %b, want 1", busy);
                else n_pass++;
                start = 1'b1;
                x_min = xm + 27'd777;
                y_max = ym - 27'd555;
                step = st + 27'd12345;
            end
            tick((t >= bp_at && t < bp_at + bp_len) ? 1'b0 : ($urandom_range(0, 3) != 0));
            start = 1'b0;
            if (abort_at >= 0 && accepted >= abort_at) begin
                #2 reset = 1'b0;
                #1;
                n_checks++;
                if (busy !== 1'b0 || pix_valid !== 1'b0 || solver_reset !== '1 || done !== 1'b0 ||
                    pix_x !== '0 || pix_y !== '0 || pix_iter !== '0 || solver_c_re !== '0)
                    $display("FAIL abort_reset: got busy=%b v=%b srst=%b done=%b, want busy=0 v=0 srst=all1 done=0",
                             busy, pix_valid, solver_reset, done);
                else
                    n_pass++;
                hold = 1'b0;
                tick(1'b0);
                tick(1'b0);
                reset = 1'b1;
                tick(1'b0);
                tick(1'b0);
                n_checks++;
                if (done_cnt != 0) $display("FAIL abort_no_done: got %0d pulses, want 0", done_cnt);
                else n_pass++;
                return;
            end
        end
        n_checks++;
        if (done_cnt != 1 || accepted != W * H)
            $display("FAIL frame_end: got done=%0d accepted=%0d, want done=1 accepted=%0d", done_cnt, accepted, W * H);
        else
            n_pass++;
        n_checks++;
        if (done_cyc != hs_cyc + 1 || done_busy !== 1'b0)
            $display("FAIL done_timing: got done cycle %0d busy=%b, want cycle %0d busy=0", done_cyc, done_busy, hs_cyc + 1);
        else
            n_pass++;
        tick(1'b1);
        n_checks++;
        if (done !== 1'b0 || done_cnt != 1) $display("FAIL done_pulse: got done=%b count=%0d, want 0/1", done, done_cnt);
        else n_pass++;
`ifdef MAND_SCHED_STATS_EN
        n_checks++;
        if (frame_cycles !== 32'(bcyc) || conv_count !== 32'(nconv))
            $display("FAIL stats: got cycles=%0d conv=%0d, want cycles=%0d conv=%0d", frame_cycles, conv_count, bcyc, nconv);
        else
            n_pass++;
`else
        n_checks++;
        if (frame_cycles !== '0 || conv_count !== '0)
            $display("FAIL stats_off: got cycles=%0d conv=%0d, want 0/0", frame_cycles, conv_count);
        else
            n_pass++;
`endif
    endtask

    task automatic test_reset();
        #12 reset = 1'b0;
        #1;
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0 || pix_valid !== 1'b0 || pix_x !== '0 || pix_y !== '0 ||
            pix_iter !== '0 || solver_reset !== '1 || solver_c_re !== '0 || solver_c_im !== '0 ||
            frame_cycles !== '0 || conv_count !== '0)
            $display("FAIL reset_state: got busy=%b done=%b v=%b srst=%b iter=%h, want busy=0 done=0 v=0 srst=all1 iter=0",
                     busy, done, pix_valid, solver_reset, pix_iter);
        else
            n_pass++;
        repeat (3) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        n_checks++;
        if (busy !== 1'b0 || solver_reset !== '1) $display("FAIL idle_after_reset: got busy=%b srst=%b, want 0/all1", busy, solver_reset);
        else n_pass++;
    endtask

    task automatic test_fixed_frame();
        run_frame(27'h7E0_0000, 27'(1 << 20), 27'(1 << 20), 10000, 0, 1'b0, -1);
    endtask

    task automatic test_random_frames();
        repeat (4)
            run_frame(27'(int'($urandom_range(0, 2600000)) - 2300000), 27'(int'($urandom_range(0, 1300000))),
                      27'($urandom_range(60000, 400000)), 10000, 0, 1'b0, -1);
    endtask

    task automatic test_back_to_back();
        run_frame(27'(-1500000), 27'(600000), 27'(250000), 10000, 0, 1'b0, -1);
        run_frame(27'(-800000), 27'(300000), 27'(90000), 10000, 0, 1'b0, -1);
    endtask

    task automatic test_backpressure();
        run_frame(27'(-1900000), 27'(900000), 27'(300000), 3, 50, 1'b0, -1);
    endtask

    task automatic test_start_ignored();
        run_frame(27'(-1200000), 27'(700000), 27'(200000), 10000, 0, 1'b1, -1);
    endtask

    task automatic test_reset_abort();
        run_frame(27'(-2000000), 27'(1000000), 27'(350000), 10000, 0, 1'b0, 3);
        run_frame(27'(-2000000), 27'(1000000), 27'(350000), 10000, 0, 1'b0, -1);
    endtask

    initial begin
        test_reset();
        test_fixed_frame();
        test_random_frames();
        test_back_to_back();
        test_backpressure();
        test_start_ignored();
        test_reset_abort();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
